compl_mul_pipe: RTL and testbench
=================================

Name: compl_mul_pipe

Overview:
- Parametrised, fully pipelined complex multiplier with a valid/ready stream handshake.
- Multiplies an integer sample a (DATA_W bits) by a fixed-point coefficient b (COEF_W bits, COEF_FRAC fractional bits).
- Supports runtime conjugation of b and selectable rounding (half-up or convergent).
- Saturates to OUT_W bits and counts saturation events; sits between the sample source and the downstream filter/accumulator chain.

Parameters:
- DATA_W, 18: width of signed a_i/a_q.
- COEF_W, 18: width of signed b_i/b_q.
- COEF_FRAC, 16: fractional bits of b (1.0 = 2^COEF_FRAC); must be ≥1 and < COEF_W.
- OUT_W, 19: width of signed output I/Q.
- CNT_W, 16: width of the saturation event counter.

Ports:
- clk_i  in  1  clock.
- arst_n_i  in  1  asynchronous reset, active-low.
- s_valid_i  in  1  input sample valid.
- s_ready_o  out  1  block accepts input this cycle.
- data_a_i_i, data_a_q_i  in  DATA_W  signed a, I/Q.
- data_b_i_i, data_b_q_i  in  COEF_W  signed b, I/Q.
- conj_i  in  1  1: compute a*conj(b); sampled with the data.
- rnd_mode_i  in  1  0: round half-up; 1: convergent (ties to even); sampled with the data.
- m_valid_o  out  1  output valid.
- m_ready_i  in  1  downstream accepts output.
- data_i_o, data_q_o  out  OUT_W  signed result, I/Q.
- sat_o  out  1  this output sample saturated (I or Q).
- sat_cnt_o  out  CNT_W  count of saturated samples, sticks at all-ones.
- clr_cnt_i  in  1  synchronous clear of sat_cnt_o.

Behaviour:
- Reset (arst_n_i=0, async): all valid bits, data_i_o, data_q_o, sat_o and sat_cnt_o go to 0 immediately. s_ready_o=1 from the first edge after release.
- Pipeline, three stages with one valid bit each:
  - S1: register inputs, conj and mode.
  - S2: register the four products ai*bi, aq*bq, ai*bq, aq*bi, each DATA_W+COEF_W bits.
  - S3: sum, round, saturate; register to outputs.
- Latency: 3 cycles from input acceptance to m_valid_o with m_ready_i held high. Throughput is 1 sample/cycle.
- Sums, full precision, DATA_W+COEF_W+1 bits:
  - conj=0: I = ai*bi - aq*bq; Q = ai*bq + aq*bi.
  - conj=1: I = ai*bi + aq*bq; Q = aq*bi - ai*bq.
- Rounding (shift right by COEF_FRAC):
  - Half-up: add 2^(COEF_FRAC-1), then arithmetic shift right.
  - Convergent: same, except an exact tie rounds to the even result.
- Saturation: if the rounded value is outside [-2^(OUT_W-1), 2^(OUT_W-1)-1], clamp to that bound. sat_o=1 if either I or Q clamped.
- Handshake:
  - Global enable en = ~m_valid_o | m_ready_i; s_ready_o = en (combinational).
  - When en=0, all stages hold data and valid.
  - Input is accepted on s_valid_i & s_ready_o.
  - Output is consumed on m_valid_o & m_ready_i.
  - Data and sat_o are stable while m_valid_o=1 and m_ready_i=0.
  - Bubbles propagate and are not collapsed. No sample is lost or duplicated.
- Counter:
  - sat_cnt_o increments by 1 on each consumed output with sat_o=1; it holds at 2^CNT_W-1.
  - clr_cnt_i has priority over a simultaneous increment: the result is 0.
- Reset mid-operation: in-flight samples are discarded; no output handshake follows.

Decomposition:
- Package compl_mul_pkg: rnd_mode enum (RND_HALF_UP=0, RND_CONV=1) and helper functions for the width calculations (product width, sum width).
- Sub-module cm_round_sat (combinational round + saturate, parametrised IN_W/FRAC/OUT_W), instantiated twice for I and Q in S3.

Test Plan:
- a=(1,0), b=(0x10000,0), conj=0, mode=0, m_ready_i=1 → (1,0) exactly 3 cycles after acceptance, sat_o=0.
- a=(24,0), b=(0x15000,0) [1.3125] → 31.5 rounds to 32 in both modes.
  - a=(1,0), b=(0x08000,0) → 1 in half-up, 0 in convergent.
  - a=(-1,0), same b → 0 in both modes.
- a=(1,1), b=(0x10000,0x10000): conj=0 → (0,2); conj=1 → (2,0).
- a=(-131072,-131072), b=(0x20000,0x1FFFF) → I=262143 (clamped from 524286), Q=2, sat_o=1, sat_cnt_o 0→1; then clr_cnt_i=1 → 0.
- Stream 8 consecutive samples, drop m_ready_i for 5 cycles mid-stream:
  - s_ready_o falls the same cycle.
  - Outputs hold stable.
  - All 8 results arrive in order, none lost or duplicated.
- 3 samples in flight, pulse arst_n_i low → m_valid_o=0 and sat_cnt_o=0 immediately; no stale output after release.

Source files
------------

// File: rtl/compl_mul_pkg.sv
// Shared types and width helpers for the pipelined complex multiplier.
package compl_mul_pkg;

    typedef enum logic {
        RND_HALF_UP = 1'b0,
        RND_CONV    = 1'b1
    } rnd_mode_e;

    function automatic int prod_w(input int data_w, input int coef_w);
        return data_w + coef_w;
    endfunction

    // One guard bit so a sum of two full-scale products cannot wrap.
    function automatic int sum_w(input int data_w, input int coef_w);
        return data_w + coef_w + 1;
    endfunction

endpackage

// File: rtl/compl_mul_pipe_if.sv
// Stream bundle between the sample source, the multiplier and the downstream chain.
// Handshake: a beat transfers on a rising clock edge where valid & ready are both 1;
// a producer holds valid and data stable until that edge, ready may depend on valid.
interface compl_mul_pipe_if #(
    parameter int DATA_W = 18,
    parameter int COEF_W = 18,
    parameter int OUT_W  = 19,
    parameter int CNT_W  = 16
);
    logic                     s_valid_i;
    logic                     s_ready_o;
    logic signed [DATA_W-1:0] data_a_i_i;
    logic signed [DATA_W-1:0] data_a_q_i;
    logic signed [COEF_W-1:0] data_b_i_i;
    logic signed [COEF_W-1:0] data_b_q_i;
    logic                     conj_i;
    logic                     rnd_mode_i;
    logic                     m_valid_o;
    logic                     m_ready_i;
    logic signed [OUT_W-1:0]  data_i_o;
    logic signed [OUT_W-1:0]  data_q_o;
    logic                     sat_o;
    logic [CNT_W-1:0]         sat_cnt_o;
    logic                     clr_cnt_i;

    modport slave (
        input  s_valid_i, data_a_i_i, data_a_q_i, data_b_i_i, data_b_q_i,
        input  conj_i, rnd_mode_i, m_ready_i, clr_cnt_i,
        output s_ready_o, m_valid_o, data_i_o, data_q_o, sat_o, sat_cnt_o
    );

    modport master (
        output s_valid_i, data_a_i_i, data_a_q_i, data_b_i_i, data_b_q_i,
        output conj_i, rnd_mode_i, m_ready_i, clr_cnt_i,
        input  s_ready_o, m_valid_o, data_i_o, data_q_o, sat_o, sat_cnt_o
    );
endinterface

// File: rtl/cm_round_sat.sv
// Combinational shift-right-by-FRAC with half-up or convergent rounding,
// followed by signed saturation to OUT_W bits.
module cm_round_sat #(
    parameter int IN_W  = 37,
    parameter int FRAC  = 16,
    parameter int OUT_W = 19
) (
    input  logic signed [IN_W-1:0]  x_i,
    input  logic                    conv_i,
    output logic signed [OUT_W-1:0] y_o,
    output logic                    sat_o
);
    localparam int RW = IN_W + 1 - FRAC;
    localparam logic [FRAC-1:0] TIE_PAT = FRAC'(1) << (FRAC - 1);

    logic [RW-1:0] half_up;
    logic [RW-1:0] rnd;
    logic          tie;

    // Adding 2^(FRAC-1) before the shift only carries into the kept part via bit FRAC-1.
    always_comb begin
        half_up = {x_i[IN_W-1], x_i[IN_W-1:FRAC]} + RW'(x_i[FRAC-1]);
        tie     = (x_i[FRAC-1:0] == TIE_PAT);
        rnd     = (conv_i && tie) ? {half_up[RW-1:1], 1'b0} : half_up;
    end

    if (RW > OUT_W) begin : g_sat
        logic [RW-OUT_W:0] top;
        always_comb begin
            top   = rnd[RW-1:OUT_W-1];
            sat_o = ~((&top) | ~(|top));
            y_o   = rnd[OUT_W-1:0];
            if (sat_o) begin
                y_o = rnd[RW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end else begin : g_ext
        assign sat_o = 1'b0;
        assign y_o   = OUT_W'($signed(rnd));
    end

endmodule

// File: rtl/compl_mul_pipe.sv
// Three-stage complex multiplier a * b (or a * conj(b)) with fixed-point b,
// rounding, saturation and a sticky saturation counter; one global stall enable.
module compl_mul_pipe
    import compl_mul_pkg::*;
#(
    parameter int DATA_W    = 18,
    parameter int COEF_W    = 18,
    parameter int COEF_FRAC = 16,
    parameter int OUT_W     = 19,
    parameter int CNT_W     = 16
) (
    input logic             clk_i,
    input logic             arst_n_i,
    compl_mul_pipe_if.slave bus
);
    localparam int PW = prod_w(DATA_W, COEF_W);
    localparam int SW = sum_w(DATA_W, COEF_W);

    logic                     en;
    logic                     v1_q, v2_q, v3_q;
    logic signed [DATA_W-1:0] a_i_q, a_q_q;
    logic signed [COEF_W-1:0] b_i_q, b_q_q;
    logic                     conj1_q, conj2_q;
    rnd_mode_e                mode1_q, mode2_q;
    logic signed [PW-1:0]     p_ii_q, p_qq_q, p_iq_q, p_qi_q;
    logic signed [SW-1:0]     sum_i, sum_q;
    logic signed [OUT_W-1:0]  rs_i, rs_q;
    logic                     sat_ch_i, sat_ch_q;
    logic signed [OUT_W-1:0]  out_i_q, out_q_q;
    logic                     sat_q;
    logic [CNT_W-1:0]         sat_cnt_q, sat_cnt_d;

    // A full output register with no taker freezes every stage; bubbles are kept.
    assign en            = ~v3_q | bus.m_ready_i;
    assign bus.s_ready_o = en;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            v1_q    <= 1'b0;
            a_i_q   <= '0;
            a_q_q   <= '0;
            b_i_q   <= '0;
            b_q_q   <= '0;
            conj1_q <= 1'b0;
            mode1_q <= RND_HALF_UP;
        end else if (en) begin
            v1_q    <= bus.s_valid_i;
            a_i_q   <= bus.data_a_i_i;
            a_q_q   <= bus.data_a_q_i;
            b_i_q   <= bus.data_b_i_i;
            b_q_q   <= bus.data_b_q_i;
            conj1_q <= bus.conj_i;
            mode1_q <= rnd_mode_e'(bus.rnd_mode_i);
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            v2_q    <= 1'b0;
            p_ii_q  <= '0;
            p_qq_q  <= '0;
            p_iq_q  <= '0;
            p_qi_q  <= '0;
            conj2_q <= 1'b0;
            mode2_q <= RND_HALF_UP;
        end else if (en) begin
            v2_q    <= v1_q;
            p_ii_q  <= PW'(a_i_q) * PW'(b_i_q);
            p_qq_q  <= PW'(a_q_q) * PW'(b_q_q);
            p_iq_q  <= PW'(a_i_q) * PW'(b_q_q);
            p_qi_q  <= PW'(a_q_q) * PW'(b_i_q);
            conj2_q <= conj1_q;
            mode2_q <= mode1_q;
        end
    end

    always_comb begin
        sum_i = SW'(p_ii_q) - SW'(p_qq_q);
        sum_q = SW'(p_iq_q) + SW'(p_qi_q);
        if (conj2_q) begin
            sum_i = SW'(p_ii_q) + SW'(p_qq_q);
            sum_q = SW'(p_qi_q) - SW'(p_iq_q);
        end
    end

    cm_round_sat #(.IN_W(SW), .FRAC(COEF_FRAC), .OUT_W(OUT_W)) u_rs_i (
        .x_i   (sum_i),
        .conv_i(mode2_q == RND_CONV),
        .y_o   (rs_i),
        .sat_o (sat_ch_i)
    );

    cm_round_sat #(.IN_W(SW), .FRAC(COEF_FRAC), .OUT_W(OUT_W)) u_rs_q (
        .x_i   (sum_q),
        .conv_i(mode2_q == RND_CONV),
        .y_o   (rs_q),
        .sat_o (sat_ch_q)
    );

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            v3_q    <= 1'b0;
            out_i_q <= '0;
            out_q_q <= '0;
            sat_q   <= 1'b0;
        end else if (en) begin
            v3_q    <= v2_q;
            out_i_q <= rs_i;
            out_q_q <= rs_q;
            sat_q   <= sat_ch_i | sat_ch_q;
        end
    end

    // Counts consumed saturated samples only; clear wins over a same-cycle increment.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (bus.clr_cnt_i) begin
            sat_cnt_d = '0;
        end else if (v3_q && bus.m_ready_i && sat_q && !(&sat_cnt_q)) begin
            sat_cnt_d = sat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign bus.m_valid_o = v3_q;
    assign bus.data_i_o  = out_i_q;
    assign bus.data_q_o  = out_q_q;
    assign bus.sat_o     = sat_q;
    assign bus.sat_cnt_o = sat_cnt_q;

endmodule

// File: tb/tb_compl_mul_pipe.sv
// Scoreboard bench for compl_mul_pipe: directed rounding/conj/saturation vectors,
// a stalled stream, counter clear/stick and an asynchronous reset mid-flight.
module tb_compl_mul_pipe;
    localparam int DATA_W    = 18;
    localparam int COEF_W    = 18;
    localparam int COEF_FRAC = 16;
    localparam int OUT_W     = 19;
    localparam int CNT_W     = 4;
    localparam int EW        = 1 + 2 * OUT_W;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic clk;
    logic arst_n;

    compl_mul_pipe_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

    compl_mul_pipe #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC), .OUT_W(OUT_W), .CNT_W(CNT_W)
    ) dut (
        .clk_i   (clk),
        .arst_n_i(arst_n),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int            acc_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            lat_last = 0;
    int            model_cnt = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint rnd_div(input longint s, input bit md);
        longint q, r, half;
        half = longint'(1) <<< (COEF_FRAC - 1);
        q    = s >>> COEF_FRAC;
        r    = s - (q <<< COEF_FRAC);
        if (r > half) q = q + 1;
        else if (r == half && (!md || q[0])) q = q + 1;
        return q;
    endfunction

    function automatic logic [EW-1:0] model(input logic signed [DATA_W-1:0] ai, aq,
                                             input logic signed [COEF_W-1:0] bi, bq,
                                             input bit cj, md);
        longint pii, pqq, piq, pqi, si, sq, ri, rq, maxv, minv;
        bit     sat;
        pii = longint'(ai) * longint'(bi);
        pqq = longint'(aq) * longint'(bq);
        piq = longint'(ai) * longint'(bq);
        pqi = longint'(aq) * longint'(bi);
        if (!cj) begin
            si = pii - pqq;
            sq = piq + pqi;
        end else begin
            si = pii + pqq;
            sq = pqi - piq;
        end
        ri   = rnd_div(si, md);
        rq   = rnd_div(sq, md);
        maxv = (longint'(1) <<< (OUT_W - 1)) - 1;
        minv = -maxv - 1;
        sat  = 1'b0;
        if (ri > maxv) begin ri = maxv; sat = 1'b1; end
        else if (ri < minv) begin ri = minv; sat = 1'b1; end
        if (rq > maxv) begin rq = maxv; sat = 1'b1; end
        else if (rq < minv) begin rq = minv; sat = 1'b1; end
        return {sat, ri[OUT_W-1:0], rq[OUT_W-1:0]};
    endfunction

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        bit            consumed;
        consumed = 1'b0;
        exp      = '0;
        if (!arst_n) begin
            exp_q.delete();
            acc_q.delete();
            model_cnt = 0;
        end else begin
            if (bus.m_valid_o) begin
                got = {bus.sat_o, bus.data_i_o, bus.data_q_o};
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else if (bus.m_ready_i) begin
                    exp = exp_q.pop_front();
                    check("out", got, exp);
                    check("sat_cnt", bus.sat_cnt_o, model_cnt);
                    lat_last = cyc - acc_q.pop_front();
                    consumed = 1'b1;
                end else begin
                    check("hold", got, exp_q[0]);
                end
            end
            if (bus.clr_cnt_i) model_cnt = 0;
            else if (consumed && exp[EW-1] && model_cnt != CNT_MAX) model_cnt = model_cnt + 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int ai, aq, bi, bq, input bit cj, md);
        logic signed [DATA_W-1:0] sai, saq;
        logic signed [COEF_W-1:0] sbi, sbq;
        int n;
        sai = ai[DATA_W-1:0];
        saq = aq[DATA_W-1:0];
        sbi = bi[COEF_W-1:0];
        sbq = bq[COEF_W-1:0];
        bus.s_valid_i  = 1'b1;
        bus.data_a_i_i = sai;
        bus.data_a_q_i = saq;
        bus.data_b_i_i = sbi;
        bus.data_b_q_i = sbq;
        bus.conj_i     = cj;
        bus.rnd_mode_i = md;
        n = 0;
        @(negedge clk);
        while (!bus.s_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.s_ready_o) begin
            exp_q.push_back(model(sai, saq, sbi, sbq, cj, md));
            acc_q.push_back(cyc);
        end else begin
            check("send_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        bus.s_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        arst_n         = 1'b0;
        bus.s_valid_i  = 1'b0;
        bus.data_a_i_i = '0;
        bus.data_a_q_i = '0;
        bus.data_b_i_i = '0;
        bus.data_b_q_i = '0;
        bus.conj_i     = 1'b0;
        bus.rnd_mode_i = 1'b0;
        bus.m_ready_i  = 1'b1;
        bus.clr_cnt_i  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_m_valid", bus.m_valid_o, 0);
        check("rst_data_i", bus.data_i_o, 0);
        check("rst_data_q", bus.data_q_o, 0);
        check("rst_sat", bus.sat_o, 0);
        check("rst_sat_cnt", bus.sat_cnt_o, 0);
        arst_n = 1'b1;
        @(negedge clk);
        check("rst_s_ready", bus.s_ready_o, 1);
        @(posedge clk);
        #1;

        // unity gain and pipeline latency
        send(1, 0, 'h10000, 0, 1'b0, 1'b0);
        wait_drain();
        check("latency", lat_last, 3);

        // rounding: 31.5 in both modes, +0.5 and -0.5 ties
        for (int m = 0; m < 2; m++) begin
            send(24, 0, 'h15000, 0, 1'b0, m[0]);
            send(1, 0, 'h08000, 0, 1'b0, m[0]);
            send(-1, 0, 'h08000, 0, 1'b0, m[0]);
        end
        // plain and conjugated product
        send(1, 1, 'h10000, 'h10000, 1'b0, 1'b0);
        send(1, 1, 'h10000, 'h10000, 1'b1, 1'b0);
        wait_drain();

        // saturation, counter increment then clear
        send(-131072, -131072, 'h20000, 'h1FFFF, 1'b0, 1'b0);
        wait_drain();
        check("sat_cnt_one", bus.sat_cnt_o, 1);
        bus.clr_cnt_i = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_cnt_i = 1'b0;
        check("sat_cnt_clr", bus.sat_cnt_o, 0);

        // clear coinciding with consumption of a saturated sample
        bus.m_ready_i = 1'b0;
        send(-131072, -131072, 'h20000, 'h1FFFF, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("stall_valid", bus.m_valid_o, 1);
        bus.m_ready_i = 1'b1;
        bus.clr_cnt_i = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_cnt_i = 1'b0;
        check("clr_priority", bus.sat_cnt_o, 0);
        wait_drain();

        // 8-sample stream with a 5-cycle downstream stall
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    send($urandom_range(0, (1 << DATA_W) - 1), $urandom_range(0, (1 << DATA_W) - 1),
                         $urandom_range(0, (1 << COEF_W) - 1), $urandom_range(0, (1 << COEF_W) - 1),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                bus.m_ready_i = 1'b0;
                #1;
                check("s_ready_stall", bus.s_ready_o, 0);
                repeat (5) @(posedge clk);
                #1;
                bus.m_ready_i = 1'b1;
            end
        join
        wait_drain();

        // counter sticks at all-ones
        bus.clr_cnt_i = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_cnt_i = 1'b0;
        for (int k = 0; k < CNT_MAX + 2; k++) begin
            send(-131072, -131072, 'h20000, 'h1FFFF, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        wait_drain();
        check("sat_cnt_stick", bus.sat_cnt_o, CNT_MAX);

        // asynchronous reset with three samples in flight
        for (int k = 0; k < 3; k++) begin
            send(100 + k, -50, 'h10000, 'h08000, 1'b0, 1'b0);
        end
        #1;
        arst_n = 1'b0;
        #1;
        check("arst_m_valid", bus.m_valid_o, 0);
        check("arst_sat_cnt", bus.sat_cnt_o, 0);
        @(posedge clk);
        #2;
        arst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("no_stale", bus.m_valid_o, 0);
        check("post_rst_cnt", bus.sat_cnt_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
